// File: rtl/i2c_tgt_mem.sv
// I2C target byte memory: filtered START/STOP decode, 7-bit address match, pointer byte, auto-incrementing transfers.
// Define I2C_TGT_MEM_HOST_EN to add a local host read/write port onto the same memory.
module i2c_tgt_mem #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int          DEPTH    = 256,
    parameter int          FILT_LEN = 3,
    localparam int         PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_t,
    output logic          busy,
    output logic          sel,
    output logic          wr_stb,
    output logic [PW-1:0] wr_addr
`ifdef I2C_TGT_MEM_HOST_EN
    ,
    input  logic          host_we,
    input  logic [PW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata
`endif
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        PTR      = 4'd3,
        PTR_ACK  = 4'd4,
        WR       = 4'd5,
        WR_ACK   = 4'd6,
        RD       = 4'd7,
        RD_ACK   = 4'd8,
        WAIT     = 4'd9
    } state_t;

    // Bit [0] of each pair is SCL, bit [1] is SDA.
    logic [1:0]    sync1_r, sync2_r, filt_r, filt_d_r;
    logic [3:0]    fcnt_r [2];
    logic          scl_rise_s, scl_fall_s, start_s, stop_s, sda_f_s;
    state_t        state_r, state_s;
    logic [3:0]    cnt_r, cnt_s;
    logic [7:0]    shift_r, shift_s;
    logic [PW-1:0] ptr_r, ptr_s;
    logic          rw_r, rw_s, ack_r, ack_s;
    logic          sda_t_s, busy_s, sel_s, wr_stb_s;
    logic [PW-1:0] wr_addr_s;
    logic          mem_we_s;
    logic [7:0]    mem_wdata_s, rd_byte_s;
    logic [7:0]    mem_r [DEPTH];

    assign sda_o      = 1'b0;
    assign sda_f_s    = filt_r[1];
    assign scl_rise_s = filt_r[0] & ~filt_d_r[0];
    assign scl_fall_s = ~filt_r[0] & filt_d_r[0];
    assign start_s    = filt_r[0] & filt_d_r[0] & filt_d_r[1] & ~filt_r[1];
    assign stop_s     = filt_r[0] & filt_d_r[0] & ~filt_d_r[1] & filt_r[1];
    assign rd_byte_s  = mem_r[ptr_r];

    // Two-flop synchroniser then a run-length filter: a new level must persist FILT_LEN samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_r   <= 2'b11;
            sync2_r   <= 2'b11;
            filt_r    <= 2'b11;
            filt_d_r  <= 2'b11;
            fcnt_r[0] <= 4'd0;
            fcnt_r[1] <= 4'd0;
        end else begin
            sync1_r  <= {sda_i, scl_i};
            sync2_r  <= sync1_r;
            filt_d_r <= filt_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= 4'd0;
                end else if (fcnt_r[i] == 4'(FILT_LEN - 1)) begin
                    filt_r[i] <= sync2_r[i];
                    fcnt_r[i] <= 4'd0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + 4'd1;
                end
            end
        end
    end

    // Protocol FSM: bus conditions override everything, data sampled on SCL rise, SDA changed on SCL fall.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        shift_s     = shift_r;
        ptr_s       = ptr_r;
        rw_s        = rw_r;
        ack_s       = ack_r;
        sda_t_s     = sda_t;
        busy_s      = busy;
        sel_s       = sel;
        wr_stb_s    = 1'b0;
        wr_addr_s   = wr_addr;
        mem_we_s    = 1'b0;
        mem_wdata_s = {shift_r[6:0], sda_f_s};
        if (start_s) begin
            state_s = ADDR;
            cnt_s   = 4'd0;
            ack_s   = 1'b0;
            busy_s  = 1'b1;
            sel_s   = 1'b0;
            sda_t_s = 1'b1;
        end else if (stop_s) begin
            state_s = IDLE;
            busy_s  = 1'b0;
            sel_s   = 1'b0;
            sda_t_s = 1'b1;
        end else if (scl_rise_s) begin
            case (state_r)
                ADDR, PTR: begin
                    shift_s = {shift_r[6:0], sda_f_s};
                    cnt_s   = cnt_r + 4'd1;
                end
                WR: begin
                    shift_s = {shift_r[6:0], sda_f_s};
                    cnt_s   = cnt_r + 4'd1;
                    if (cnt_r == 4'd7) begin
                        mem_we_s  = 1'b1;
                        wr_stb_s  = 1'b1;
                        wr_addr_s = ptr_r;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                RD: cnt_s = cnt_r + 4'd1;
                RD_ACK: begin
                    // Every byte handed out advances the pointer, whether the master ACKs it or not.
                    ptr_s = ptr_r + PW'(1'b1);
                    if (sda_f_s == 1'b0) begin
                        ack_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                    end
                end
                default: state_s = state_r;
            endcase
        end else if (scl_fall_s) begin
            case (state_r)
                ADDR: begin
                    if (cnt_r != 4'd8) begin
                        state_s = ADDR;
                    end else if (shift_r[7:1] == DEV_ADDR && shift_r[7:1] != 7'h00) begin
                        state_s = ADDR_ACK;
                        sel_s   = 1'b1;
                        sda_t_s = 1'b0;
                        rw_s    = shift_r[0];
                    end else begin
                        state_s = WAIT;
                    end
                end
                PTR: begin
                    if (cnt_r == 4'd8) begin
                        ptr_s   = shift_r[PW-1:0];
                        state_s = PTR_ACK;
                        sda_t_s = 1'b0;
                    end else begin
                        state_s = PTR;
                    end
                end
                WR: begin
                    if (cnt_r == 4'd8) begin
                        state_s = WR_ACK;
                        sda_t_s = 1'b0;
                    end else begin
                        state_s = WR;
                    end
                end
                ADDR_ACK: begin
                    cnt_s = 4'd0;
                    if (rw_r) begin
                        state_s = RD;
                        shift_s = rd_byte_s;
                        sda_t_s = rd_byte_s[7];
                    end else begin
                        state_s = PTR;
                        sda_t_s = 1'b1;
                    end
                end
                PTR_ACK: begin
                    state_s = WR;
                    cnt_s   = 4'd0;
                    sda_t_s = 1'b1;
                end
                WR_ACK: begin
                    state_s = WR;
                    cnt_s   = 4'd0;
                    sda_t_s = 1'b1;
                    ptr_s   = ptr_r + PW'(1'b1);
                end
                RD: begin
                    if (cnt_r == 4'd8) begin
                        state_s = RD_ACK;
                        sda_t_s = 1'b1;
                        ack_s   = 1'b0;
                    end else begin
                        shift_s = {shift_r[6:0], 1'b0};
                        sda_t_s = shift_r[6];
                    end
                end
                RD_ACK: begin
                    if (ack_r) begin
                        state_s = RD;
                        cnt_s   = 4'd0;
                        ack_s   = 1'b0;
                        shift_s = rd_byte_s;
                        sda_t_s = rd_byte_s[7];
                    end else begin
                        state_s = RD_ACK;
                    end
                end
                default: state_s = state_r;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            shift_r <= 8'h00;
            ptr_r   <= '0;
            rw_r    <= 1'b0;
            ack_r   <= 1'b0;
            sda_t   <= 1'b1;
            busy    <= 1'b0;
            sel     <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            ptr_r   <= ptr_s;
            rw_r    <= rw_s;
            ack_r   <= ack_s;
            sda_t   <= sda_t_s;
            busy    <= busy_s;
            sel     <= sel_s;
            wr_stb  <= wr_stb_s;
            wr_addr <= wr_addr_s;
        end
    end

    // Memory array, deliberately not reset; the I2C write is last so it wins a same-address collision.
    always_ff @(posedge clk) begin
`ifdef I2C_TGT_MEM_HOST_EN
        if (host_we) begin
            mem_r[host_addr] <= host_wdata;
        end
`endif
        if (mem_we_s) begin
            mem_r[ptr_r] <= mem_wdata_s;
        end
    end

`ifdef I2C_TGT_MEM_HOST_EN
    // Host read port with one clock of latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            host_rdata <= 8'h00;
        end else begin
            host_rdata <= mem_r[host_addr];
        end
    end
`endif

endmodule

// File: tb/tb_i2c_tgt_mem.sv
// Self-checking bench for i2c_tgt_mem: bit-banged I2C master, transaction-level memory model, randomized traffic.
`timescale 1ns/1ps
module tb_i2c_tgt_mem;
    localparam int DEPTH = 16;
    localparam int PW    = 4;
    localparam int Q     = 5;
    localparam logic [7:0] A_WR = 8'hA0;
    localparam logic [7:0] A_RD = 8'hA1;

    logic          clk = 1'b0;
    logic          resetn, scl_m, sda_m, sda_i;
    logic          sda_o, sda_t, busy, sel, wr_stb;
    logic [PW-1:0] wr_addr;

    logic [7:0] mm [DEPTH];
    bit         mv [DEPTH];
    int         ptr_m;
    int         exp_q[$];
    int         got_q[$];
    logic [7:0] wbuf [8];
    logic [7:0] rbuf [8];
    int         checks = 0;
    int         errors = 0;
    logic       cmp_en = 1'b0;
    logic       exp_busy = 1'b0;
    logic       exp_sel = 1'b0;
    logic       exp_rel = 1'b1;

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull SDA low.
    assign sda_i = sda_m & (sda_t | sda_o);

    i2c_tgt_mem #(.DEV_ADDR(7'h50), .DEPTH(DEPTH), .FILT_LEN(3)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .scl_i   (scl_m),
        .sda_i   (sda_i),
        .sda_o   (sda_o),
        .sda_t   (sda_t),
        .busy    (busy),
        .sel     (sel),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of status outputs while they are settled.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", int'(busy), int'(exp_busy));
            check("sel", int'(sel), int'(exp_sel));
            check("sda_o", int'(sda_o), 0);
            if (exp_rel) check("sda_released", int'(sda_t), 1);
        end
    end

    always @(negedge clk) begin
        if (wr_stb === 1'b1) got_q.push_back(int'(wr_addr));
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b, output logic rb);
        sda_m = b;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        rb = sda_i;
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_start();
        cmp_en = 1'b0;
        sda_m = 1'b1;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        sda_m = 1'b0;
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(Q);
        exp_busy = 1'b1;
        exp_sel  = 1'b0;
        exp_rel  = 1'b1;
        cmp_en   = 1'b1;
    endtask

    task automatic i2c_stop();
        cmp_en = 1'b0;
        sda_m = 1'b0;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        sda_m = 1'b1;
        wait_clks(2 * Q);
        exp_busy = 1'b0;
        exp_sel  = 1'b0;
        exp_rel  = 1'b1;
        cmp_en   = 1'b1;
    endtask

    task automatic do_addr(input logic [7:0] a, input logic exp_ack);
        logic rb;
        for (int i = 7; i >= 1; i--) bit_out(a[i], rb);
        cmp_en = 1'b0;
        bit_out(a[0], rb);
        bit_out(1'b1, rb);
        check("addr_ack", int'(rb), exp_ack ? 0 : 1);
        exp_sel = exp_ack;
        exp_rel = ~exp_ack;
        cmp_en  = 1'b1;
    endtask

    task automatic do_wbyte(input logic [7:0] b, input logic exp_ack, input logic is_ptr);
        logic rb;
        for (int i = 7; i >= 0; i--) bit_out(b[i], rb);
        bit_out(1'b1, rb);
        check(is_ptr ? "ptr_ack" : "wr_ack", int'(rb), exp_ack ? 0 : 1);
        if (exp_ack && is_ptr) begin
            ptr_m = int'(b) % DEPTH;
        end else if (exp_ack) begin
            mm[ptr_m] = b;
            mv[ptr_m] = 1'b1;
            exp_q.push_back(ptr_m);
            ptr_m = (ptr_m + 1) % DEPTH;
        end
    endtask

    task automatic do_rbyte(input logic master_ack, output logic [7:0] got);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            bit_out(1'b1, rb);
            got[i] = rb;
        end
        bit_out(~master_ack, rb);
        if (mv[ptr_m]) check("rd_data", int'(got), int'(mm[ptr_m]));
        ptr_m = (ptr_m + 1) % DEPTH;
    endtask

    task automatic chk_wr();
        check("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check("wr_addr", got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic tr_write(input int p, input int n);
        i2c_start();
        do_addr(A_WR, 1'b1);
        do_wbyte(8'(p), 1'b1, 1'b1);
        for (int k = 0; k < n; k++) do_wbyte(wbuf[k], 1'b1, 1'b0);
        i2c_stop();
    endtask

    task automatic tr_read(input logic use_ptr, input int p, input int n);
        logic [7:0] d;
        i2c_start();
        if (use_ptr) begin
            do_addr(A_WR, 1'b1);
            do_wbyte(8'(p), 1'b1, 1'b1);
            i2c_start();
        end
        do_addr(A_RD, 1'b1);
        for (int k = 0; k < n; k++) begin
            do_rbyte(k < n - 1, d);
            rbuf[k] = d;
        end
        i2c_stop();
        chk_wr();
    endtask

    task automatic tr_badaddr(input logic [6:0] a7, input logic rw);
        i2c_start();
        do_addr({a7, rw}, 1'b0);
        do_wbyte(8'($urandom), 1'b0, 1'b0);
        i2c_stop();
        chk_wr();
    endtask

    task automatic tr_abort(input int p, input logic [7:0] b, input int k);
        logic rb;
        i2c_start();
        do_addr(A_WR, 1'b1);
        do_wbyte(8'(p), 1'b1, 1'b1);
        for (int i = 0; i < k; i++) bit_out(b[7-i], rb);
        i2c_stop();
        chk_wr();
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic rb;
        int   kind, n;
        logic [6:0] a7;
        resetn = 1'b0;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        ptr_m  = 0;
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        wait_clks(5);
        check("rst_sda_t", int'(sda_t), 1);
        check("rst_sda_o", int'(sda_o), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_wr_stb", int'(wr_stb), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        resetn = 1'b1;
        wait_clks(3);
        cmp_en = 1'b1;

        // Directed scenarios with literal expectations.
        wbuf[0] = 8'h55;
        tr_write(5, 1);
        chk_wr();
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        tr_write(3, 2);
        check("wr_pulses_3_4", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("wr_addr_first", got_q[0], 3);
            check("wr_addr_second", got_q[1], 4);
        end
        chk_wr();
        tr_read(1'b1, 3, 2);
        check("rd_lit_0", int'(rbuf[0]), 8'h11);
        check("rd_lit_1", int'(rbuf[1]), 8'h22);
        tr_read(1'b0, 0, 1);
        check("rd_ptr_after_nack", int'(rbuf[0]), 8'h55);
        tr_badaddr(7'h51, 1'b0);
        tr_badaddr(7'h00, 1'b0);
        wbuf[0] = 8'hAA;
        wbuf[1] = 8'hBB;
        tr_write(8'h0F, 2);
        chk_wr();
        tr_read(1'b1, 8'h0F, 2);
        check("wrap_lit_15", int'(rbuf[0]), 8'hAA);
        check("wrap_lit_0", int'(rbuf[1]), 8'hBB);
        tr_abort(3, 8'hFF, 4);
        tr_read(1'b1, 3, 1);
        check("abort_unchanged", int'(rbuf[0]), 8'h11);

        // Reset in the middle of a read while the target is pulling SDA low.
        wbuf[0] = 8'h05;
        tr_write(2, 1);
        chk_wr();
        i2c_start();
        do_addr(A_WR, 1'b1);
        do_wbyte(8'h02, 1'b1, 1'b1);
        i2c_start();
        do_addr(A_RD, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bit_out(1'b1, rb);
            check("midrd_bit", int'(rb), int'(mm[2][7-i]));
        end
        wait_clks(5);
        check("midrd_drive_low", int'(sda_t), int'(mm[2][4]));
        cmp_en = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrd_rst_sda_t", int'(sda_t), 1);
        check("midrd_rst_busy", int'(busy), 0);
        check("midrd_rst_sel", int'(sel), 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clks(4);
        resetn = 1'b1;
        ptr_m = 0;
        exp_busy = 1'b0;
        exp_sel  = 1'b0;
        exp_rel  = 1'b1;
        chk_wr();
        wait_clks(4);
        cmp_en = 1'b1;
        tr_read(1'b0, 0, 1);
        check("post_rst_mem0", int'(rbuf[0]), 8'hBB);

        // Randomized transactions against the model.
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                    tr_write($urandom_range(0, 255), n);
                    chk_wr();
                end
                1: tr_read(1'b1, $urandom_range(0, 255), $urandom_range(1, 4));
                2: tr_read(1'b0, 0, $urandom_range(1, 3));
                3: begin
                    a7 = 7'($urandom);
                    if (a7 == 7'h50) a7 = 7'h00;
                    tr_badaddr(a7, 1'($urandom));
                end
                default: tr_abort($urandom_range(0, 255), 8'($urandom), $urandom_range(1, 6));
            endcase
        end

        wait_clks(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
